// File: rtl/serial_bit_feeder.sv
// serial_bit_feeder: parallel-to-serial word feeder for the sequence detector
// Ports: clk, rst (sync, active-high); load_valid/load_data/load_ready word handshake;
// x serial bit, bit_valid (data or parity bit on x), frame_last (final bit of frame).
// Option: define SER_PARITY_EN to append an even-parity bit to every frame.
module serial_bit_feeder #(
  parameter int WIDTH = 8,
  parameter logic IDLE_LEVEL = 1'b0,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             x,
  output logic             bit_valid,
  output logic             frame_last
);
  localparam int CW = $clog2(WIDTH + 1);
`ifdef SER_PARITY_EN
  localparam bit PAR_EN = 1'b1;
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
  logic par;
`else
  localparam bit PAR_EN = 1'b0;
  typedef enum logic {IDLE, SHIFT} state_t;
`endif
  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] sreg;
  logic last_data, accept;
  function automatic logic head(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction
  function automatic logic [WIDTH-1:0] shifted(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? v << 1 : v >> 1;
  endfunction
  // cnt is the index of the data bit currently on x; sreg holds the bits still to go
  always_comb begin
    last_data = state == SHIFT && cnt == CW'(WIDTH - 1);
`ifdef SER_PARITY_EN
    load_ready = !rst && (state == IDLE || state == PAR);
    accept = load_valid && load_ready;
    state_nxt = (accept || (state == SHIFT && !last_data)) ? SHIFT : last_data ? PAR : IDLE;
`else
    load_ready = !rst && (state == IDLE || last_data);
    accept = load_valid && load_ready;
    state_nxt = (accept || (state == SHIFT && !last_data)) ? SHIFT : IDLE;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      sreg <= '0;
      x <= IDLE_LEVEL;
      bit_valid <= 1'b0;
      frame_last <= 1'b0;
`ifdef SER_PARITY_EN
      par <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt <= '0;
        sreg <= shifted(load_data);
        x <= head(load_data);
        bit_valid <= 1'b1;
        frame_last <= 1'b0;
`ifdef SER_PARITY_EN
        par <= ^load_data;
`endif
      end else if (state == SHIFT && !last_data) begin
        cnt <= cnt + CW'(1);
        sreg <= shifted(sreg);
        x <= head(sreg);
        bit_valid <= 1'b1;
        frame_last <= !PAR_EN && cnt == CW'(WIDTH - 2);
`ifdef SER_PARITY_EN
      end else if (last_data) begin
        x <= par;
        bit_valid <= 1'b1;
        frame_last <= 1'b1;
`endif
      end else begin
        x <= IDLE_LEVEL;
        bit_valid <= 1'b0;
        frame_last <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_serial_bit_feeder.sv
// tb_serial_bit_feeder: scoreboard bench for serial_bit_feeder
module tb_serial_bit_feeder;
  localparam int W = 8;
`ifdef SER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, lv = 1'b0, lv2 = 1'b0;
  logic [W-1:0] ld = '0, ld2 = '0;
  logic ready, x, bv, fl, ready2, x2, bv2, fl2;
  typedef struct packed {logic b; logic last;} ent_t;
  ent_t q[$];
  int total = 0, passed = 0;
  always #5 clk = ~clk;
  serial_bit_feeder #(.WIDTH(W), .IDLE_LEVEL(1'b0), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .load_valid(lv), .load_data(ld), .load_ready(ready),
    .x(x), .bit_valid(bv), .frame_last(fl));
  serial_bit_feeder #(.WIDTH(W), .IDLE_LEVEL(1'b1), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .load_valid(lv2), .load_data(ld2), .load_ready(ready2),
    .x(x2), .bit_valid(bv2), .frame_last(fl2));
  task automatic push(input logic [W-1:0] w);
    logic p;
    p = 1'b0;
    for (int k = 0; k < W; k++) begin
      p = p ^ w[W-1-k];
      q.push_back('{w[W-1-k], !PAR && k == W - 1});
    end
    if (PAR) q.push_back('{p, 1'b1});
  endtask
  always @(posedge clk)
    if (rst) q.delete();
    else if (lv && ready) push(ld);
  task automatic chk(input string tag, input logic o, input logic e);
    total++;
    assert (o === e) passed++;
    else $error("FAIL %s: observed %b expected %b", tag, o, e);
  endtask
  task automatic tick;
    ent_t e;
    @(negedge clk);
    chk("load_ready", ready, !rst && q.size() <= 1);
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("x", x, e.b);
      chk("bit_valid", bv, 1'b1);
      chk("frame_last", fl, e.last);
    end else begin
      chk("x_idle", x, 1'b0);
      chk("bit_valid_idle", bv, 1'b0);
      chk("frame_last_idle", fl, 1'b0);
    end
  endtask
  initial begin
    repeat (2) @(posedge clk);
    tick;
    chk("l_ready_rst", ready2, 1'b0);
    chk("l_x_rst", x2, 1'b1);
    rst = 1'b0;
    repeat (20) begin
      tick;
      chk("l_idle_x", x2, 1'b1);
      chk("l_idle_bv", bv2, 1'b0);
      chk("l_idle_ready", ready2, 1'b1);
    end
    lv = 1'b1; ld = 8'h0A; tick;
    lv = 1'b0; ld = 8'hFF; repeat (10) tick;
    lv = 1'b1; ld = 8'hA5; tick;
    ld = 8'h3C; repeat (8) tick;
    lv = 1'b0; repeat (12) tick;
    lv = 1'b1; ld = 8'hFF; tick;
    lv = 1'b0; repeat (3) tick;
    rst = 1'b1; tick;
    rst = 1'b0; lv = 1'b1; ld = 8'h80; tick;
    lv = 1'b0; ld = 8'h55; repeat (12) tick;
    lv2 = 1'b1; ld2 = 8'h01;
    chk("l_ready_pre", ready2, 1'b1);
    tick;
    lv2 = 1'b0; ld2 = 8'hFE;
    for (int k = 0; k < W; k++) begin
      chk("l_x", x2, k == 0);
      chk("l_bv", bv2, 1'b1);
      chk("l_fl", fl2, !PAR && k == W - 1);
      chk("l_ready", ready2, !PAR && k == W - 1);
      tick;
    end
    if (PAR) begin
      chk("l_par_x", x2, 1'b1);
      chk("l_par_fl", fl2, 1'b1);
      tick;
    end
    chk("l_post_x", x2, 1'b1);
    chk("l_post_bv", bv2, 1'b0);
    chk("l_post_fl", fl2, 1'b0);
    repeat (3) tick;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
